// File: rtl/snake_ctrl.sv
// snake_ctrl: game controller for the snake body stage.
// Generates the move strobe (valid), the committed move direction and the run enable
// from a programmable tick. Filters player keys so the snake never reverses in one move,
// runs the idle/run/pause/over game FSM and pulses game_rst between games. Each
// snake_score speeds up the tick once per SCORE_PER_LEVEL scores; snake_lose ends the game.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   key_up/down/left/right       debounced direction key levels
//   key_start                    start/pause/restart key level
//   snake_score                  one-cycle eat pulse from the body stage
//   snake_lose                   lose level from the body stage
//   enb                          high while the game is running
//   direction                    committed move direction, updated with valid
//   valid                        one-cycle move strobe
//   game_rst                     body-stage re-init pulse
//   game_state                   0 idle, 1 run, 2 pause, 3 over
//   score_count                  saturating score for the current game
module snake_ctrl #(
  parameter int unsigned TICK_WIDTH      = 25,
  parameter int unsigned TICK_PERIOD     = 25000000,
  parameter int unsigned TICK_STEP       = 1000000,
  parameter int unsigned TICK_MIN        = 5000000,
  parameter int unsigned SCORE_PER_LEVEL = 4,
  parameter int unsigned DIRECTION_WIDTH = 2,
  parameter logic [DIRECTION_WIDTH-1:0] DIR_UP    = 2'b00,
  parameter logic [DIRECTION_WIDTH-1:0] DIR_DOWN  = 2'b11,
  parameter logic [DIRECTION_WIDTH-1:0] DIR_LEFT  = 2'b10,
  parameter logic [DIRECTION_WIDTH-1:0] DIR_RIGHT = 2'b01
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_up,
  input  logic                       key_down,
  input  logic                       key_left,
  input  logic                       key_right,
  input  logic                       key_start,
  input  logic                       snake_score,
  input  logic                       snake_lose,
  output logic                       enb,
  output logic [DIRECTION_WIDTH-1:0] direction,
  output logic                       valid,
  output logic                       game_rst,
  output logic [1:0]                 game_state,
  output logic [7:0]                 score_count
);

  localparam int unsigned TW1 = TICK_WIDTH + 1;
  localparam int unsigned LEVEL_WIDTH = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST = LEVEL_WIDTH'(SCORE_PER_LEVEL - 1);
  localparam logic [TICK_WIDTH-1:0] PERIOD_INIT = TICK_WIDTH'(TICK_PERIOD);
  localparam logic [TW1-1:0] STEP_EXT = TW1'(TICK_STEP);
  localparam logic [TW1-1:0] MIN_EXT  = TW1'(TICK_MIN);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPause = 2'd2, StOver = 2'd3} state_e;

  state_e state_q, state_d;

  logic [4:0]                 key_q, key_now, key_rise;
  logic                       start_rise, run, tick;
  logic [DIRECTION_WIDTH-1:0] direction_q, direction_d, pending_q, pending_d, ref_inv;
  logic [TICK_WIDTH-1:0]      cnt_q, cnt_d, period_q, period_d, period_dec;
  logic [TW1-1:0]             period_ext;
  logic [LEVEL_WIDTH-1:0]     level_q, level_d;
  logic [7:0]                 score_q, score_d;
  logic                       valid_q, valid_d, enb_q, enb_d, game_rst_q, game_rst_d;

  assign key_now    = {key_start, key_right, key_left, key_down, key_up};
  assign key_rise   = key_now & ~key_q;
  assign start_rise = key_rise[4];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; lose beats a simultaneous start edge in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_rise) state_d = StRun;
      StRun: begin
        if (snake_lose)      state_d = StOver;
        else if (start_rise) state_d = StPause;
      end
      StPause: if (start_rise) state_d = StRun;
      StOver:  if (start_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign run = (state_q == StRun);
  // >= rather than == so a shrunken period fires immediately on an already-large count.
  // Ticks are suppressed on the cycle RUN is left so valid never appears outside RUN.
  assign tick = run && (state_d == StRun) &&
                (({1'b0, cnt_q} + TW1'(1)) >= {1'b0, period_q});
  // A key in a tick cycle is judged against the direction about to be committed
  assign ref_inv = ~(tick ? pending_q : direction_q);

  // Saturating period reduction, widened by one bit so the subtraction cannot wrap
  assign period_ext = {1'b0, period_q};
  assign period_dec = (period_ext < (STEP_EXT + MIN_EXT)) ? TICK_WIDTH'(MIN_EXT)
                                                          : TICK_WIDTH'(period_ext - STEP_EXT);

  // Datapath and output next-state logic
  always_comb begin
    direction_d = direction_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    level_d     = level_q;
    score_d     = score_q;
    valid_d     = 1'b0;
    game_rst_d  = 1'b0;
    enb_d       = (state_d == StRun);

    case (state_q)
      StRun:   cnt_d = tick ? '0 : cnt_q + TICK_WIDTH'(1);
      StPause: cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase

    if (tick) begin
      direction_d = pending_q;
      valid_d     = 1'b1;
    end

    // Priority up > down > left > right; an illegal key falls through to the next
    if (run) begin
      if (key_rise[0] && (DIR_UP != ref_inv))         pending_d = DIR_UP;
      else if (key_rise[1] && (DIR_DOWN != ref_inv))  pending_d = DIR_DOWN;
      else if (key_rise[2] && (DIR_LEFT != ref_inv))  pending_d = DIR_LEFT;
      else if (key_rise[3] && (DIR_RIGHT != ref_inv)) pending_d = DIR_RIGHT;
    end

    if (run && snake_score) begin
      score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
      if (level_q == LEVEL_LAST) begin
        level_d  = '0;
        period_d = period_dec;
      end else begin
        level_d = level_q + LEVEL_WIDTH'(1);
      end
    end

    // Restart from OVER: re-init the body stage and all game state
    if ((state_q == StOver) && start_rise) begin
      game_rst_d  = 1'b1;
      direction_d = DIR_RIGHT;
      pending_d   = DIR_RIGHT;
      period_d    = PERIOD_INIT;
      cnt_d       = '0;
      level_d     = '0;
      score_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '1;
      direction_q <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      cnt_q       <= '0;
      period_q    <= PERIOD_INIT;
      level_q     <= '0;
      score_q     <= '0;
      valid_q     <= 1'b0;
      enb_q       <= 1'b0;
      game_rst_q  <= 1'b1;
    end else begin
      key_q       <= key_now;
      direction_q <= direction_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      level_q     <= level_d;
      score_q     <= score_d;
      valid_q     <= valid_d;
      enb_q       <= enb_d;
      game_rst_q  <= game_rst_d;
    end
  end

  assign enb         = enb_q;
  assign direction   = direction_q;
  assign valid       = valid_q;
  assign game_rst    = game_rst_q;
  assign game_state  = state_q;
  assign score_count = score_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl with a fast tick (period 8, step 2, min 4, 2 scores per level).
// Stimulus pushes each expected move strobe (cycle and direction) into a queue; the
// monitor pops on every valid and flags late, early, missing or unexpected strobes.
module tb_snake_ctrl;

  localparam logic [4:0] K_UP    = 5'b00001;
  localparam logic [4:0] K_DOWN  = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_START = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       key_start = 1'b0, snake_score = 1'b0, snake_lose = 1'b0;
  logic       enb, valid, game_rst;
  logic [1:0] direction, game_state;
  logic [7:0] score_count;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         at;
    logic [1:0] dir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  snake_ctrl #(
    .TICK_WIDTH     (25),
    .TICK_PERIOD    (8),
    .TICK_STEP      (2),
    .TICK_MIN       (4),
    .SCORE_PER_LEVEL(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_start  (key_start),
    .snake_score(snake_score),
    .snake_lose (snake_lose),
    .enb        (enb),
    .direction  (direction),
    .valid      (valid),
    .game_rst   (game_rst),
    .game_state (game_state),
    .score_count(score_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "timeout");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL valid_missing: expected strobe at cycle %0d, absent by cycle %0d",
               sb[0].at, cyc);
      void'(sb.pop_front());
    end
    if (valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL valid_unexpected: strobe at cycle %0d dir %b, none required",
                 cyc, direction);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.at != cyc || mon_e.dir != direction) begin
          errors++;
          $display("FAIL valid_move: got cycle %0d dir %b, required cycle %0d dir %b",
                   cyc, direction, mon_e.at, mon_e.dir);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic press(input logic [4:0] k);
    {key_start, key_right, key_left, key_down, key_up} = k;
    step();
    {key_start, key_right, key_left, key_down, key_up} = 5'b0;
  endtask

  task automatic score_pulse();
    snake_score = 1'b1;
    step();
    snake_score = 1'b0;
  endtask

  task automatic push(input int at, input logic [1:0] d);
    exp_t e;
    e.at  = at;
    e.dir = d;
    sb.push_back(e);
  endtask

  initial begin
    int r, s, t, u, v, w0, w, x;

    // Reset and start
    repeat (3) step();
    rst = 1'b0;
    r = cyc;
    check("rst_game_rst", game_rst, 1);
    check("rst_state", game_state, 0);
    check("rst_enb", enb, 0);
    check("rst_valid", valid, 0);
    check("rst_direction", direction, 1);
    check("rst_score", score_count, 0);
    step();
    check("game_rst_drop", game_rst, 0);
    check("idle_state", game_state, 0);
    s = cyc;
    push(s + 9, 2'b01);
    push(s + 17, 2'b01);
    press(K_START);
    check("start_state", game_state, 1);
    check("start_enb", enb, 1);

    // Reversal rejected, then up accepted, then reversal of up rejected
    t = s + 17;
    push(t + 8, 2'b01);
    push(t + 16, 2'b00);
    push(t + 24, 2'b00);
    wait_to(t + 1);
    press(K_LEFT);
    wait_to(t + 9);
    check("left_rejected_dir", direction, 1);
    press(K_UP);
    wait_to(t + 17);
    press(K_DOWN);

    // Simultaneous keys and a key landing in a tick cycle
    u = t + 24;
    push(u + 8, 2'b01);
    push(u + 16, 2'b00);
    push(u + 24, 2'b01);
    push(u + 32, 2'b00);
    push(u + 40, 2'b10);
    push(u + 48, 2'b10);
    wait_to(u + 1);
    press(K_RIGHT);
    wait_to(u + 9);
    press(K_UP | K_RIGHT);
    wait_to(u + 17);
    press(K_RIGHT);
    wait_to(u + 25);
    press(K_LEFT | K_UP);
    wait_to(u + 33);
    press(K_DOWN | K_LEFT);
    wait_to(u + 39);
    press(K_RIGHT);

    // Pause with the counter at 5; a key during pause is ignored
    v = u + 48;
    push(v + 13, 2'b10);
    push(v + 21, 2'b10);
    wait_to(v + 5);
    press(K_START);
    check("pause_state", game_state, 2);
    check("pause_enb", enb, 0);
    wait_to(v + 8);
    press(K_UP);
    wait_to(v + 10);
    press(K_START);
    check("resume_state", game_state, 1);

    // Two scores: period 8 -> 6
    w0 = v + 21;
    push(w0 + 6, 2'b10);
    push(w0 + 12, 2'b10);
    wait_to(w0 + 1);
    score_pulse();
    score_pulse();
    check("score_two", score_count, 2);

    // Period 6 -> 4 with the count already past the new limit, then clamp at 4
    w = w0 + 12;
    push(w + 5, 2'b10);
    push(w + 9, 2'b10);
    push(w + 13, 2'b10);
    push(w + 17, 2'b10);
    wait_to(w + 2);
    score_pulse();
    score_pulse();
    wait_to(w + 10);
    score_pulse();
    score_pulse();
    check("score_six", score_count, 6);

    // Lose together with start, then restart to idle
    x = w + 17;
    wait_to(x + 1);
    snake_lose = 1'b1;
    press(K_START);
    check("over_state", game_state, 3);
    check("over_enb", enb, 0);
    wait_to(x + 6);
    snake_lose = 1'b0;
    press(K_START);
    check("restart_state", game_state, 0);
    check("restart_game_rst", game_rst, 1);
    check("restart_score", score_count, 0);
    check("restart_direction", direction, 1);
    check("restart_enb", enb, 0);
    step();
    check("restart_game_rst_drop", game_rst, 0);
    wait_to(x + 20);
    check("strobes_outstanding", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
Name: snake_ctrl

Overview:
- Game controller directly upstream of the snake body stage. Generates that stage's `enb`, `direction` and one-cycle `valid` move strobe from a programmable game tick.
- Turns player key presses into a legal direction: no 180° reversal within one move.
- Runs the game state machine (idle/run/pause/over) and issues a body re-init pulse between games.
- Consumes `snake_score` to speed up the tick and `snake_lose` to end the game.

Parameters:
- TICK_WIDTH, 25, width of the tick counter and period registers.
- TICK_PERIOD, 25000000, initial clocks between moves (0.5 s at 50 MHz).
- TICK_STEP, 1000000, period reduction per speed level.
- TICK_MIN, 5000000, lower bound of the period.
- SCORE_PER_LEVEL, 4, scores needed per speed-up.
- DIRECTION_WIDTH, 2, direction width.
- DIR_UP / DIR_DOWN / DIR_LEFT / DIR_RIGHT, 2'b00 / 2'b11 / 2'b10 / 2'b01, direction encodings. The opposite direction is always the bitwise inverse.

Ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- key_up / key_down / key_left / key_right  in  1 each  level inputs, already synchronised and debounced.
- key_start  in  1  start/pause/restart button level.
- snake_score  in  1  one-cycle eat pulse from the body stage.
- snake_lose  in  1  level lose flag from the body stage.
- enb  out  1  high only in RUN.
- direction  out  DIRECTION_WIDTH  committed move direction; stable while valid is high.
- valid  out  1  one-cycle move strobe.
- game_rst  out  1  body-stage reset pulse.
- game_state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- score_count  out  8  total scores this game; saturates at 255.

Behaviour:
- Clocking and reset:
  - Single clock domain, fully synchronous. All state updates on the rising clk edge.
  - Reset values: state IDLE, enb 0, valid 0, direction DIR_RIGHT, pending DIR_RIGHT, game_rst 1 (one cycle after rst drops, then 0), score_count 0, period TICK_PERIOD, tick counter 0, level counter 0.
  - Key history registers reset to 1, so keys held through reset produce no edge.
- Edge detection: rise = key & ~key_q.
  - Start edges drive the FSM.
  - Direction key edges update the pending direction.
- FSM:
  - IDLE: start edge -> RUN.
  - RUN: snake_lose=1 -> OVER (wins over a simultaneous start edge). Otherwise start edge -> PAUSE.
  - PAUSE: start edge -> RUN.
  - OVER: start edge -> IDLE. The same edge asserts game_rst for exactly 1 cycle and clears direction/pending to DIR_RIGHT, period to TICK_PERIOD, counters to 0, and score_count to 0.
- Tick counter:
  - Increments only in RUN. Holds its value in PAUSE. Cleared in IDLE and OVER.
  - When the counter equals period-1 in RUN ("tick"): counter <= 0, direction <= pending, valid <= 1 on the next cycle only.
  - Latency: the valid edge coincides with the direction update.
- Direction filter:
  - A key edge is accepted only if the key is not the bitwise inverse of the reference direction.
  - The reference direction is pending in a tick cycle, otherwise direction.
  - Accepted key writes pending. A key edge in a tick cycle affects the next tick only.
  - Multiple key edges in one cycle: priority up > down > left > right. A rejected higher-priority key does not block a lower-priority legal one.
  - Key edges outside RUN are ignored.
- Scoring:
  - snake_score is honoured in RUN only. It increments score_count (saturating) and the level counter.
  - When the level counter reaches SCORE_PER_LEVEL, the level counter clears and period <= max(period-TICK_STEP, TICK_MIN). Compute in TICK_WIDTH+1 bits with no underflow.
  - The new period takes effect on the current count. If the counter is already ≥ new period-1, the next cycle is a tick.
- Outputs:
  - enb = (state == RUN), registered.
  - valid is never high outside RUN.
  - rst mid-game returns every state element to its reset value in the next cycle.

Test Plan:
Bench parameters: TICK_PERIOD=8, TICK_STEP=2, TICK_MIN=4, SCORE_PER_LEVEL=2.
- Reset, then a start pulse -> game_state=1, enb=1. valid pulses every 8 clks with direction=01. game_rst is high only in the first cycle after reset.
- In RUN with direction=01, a key_left edge -> rejected, direction stays 01. Then key_up -> at the next tick direction=00. Then key_down -> rejected.
- key_up and key_right edges in the same non-tick cycle (direction=01) -> pending=00. key_left and key_up edges together with direction=01 -> left rejected, up accepted.
- snake_score 2x -> period 6, score_count=2. Then 4 more -> period 4 (clamped: 6->4->4), score_count=6. Tick spacing is measured at each step.
- In RUN with the counter at 5, start edge -> PAUSE, no valid. Resume -> the next valid arrives exactly 3 clks later.
- snake_lose=1 together with a start edge -> OVER with no further valid. A further start edge -> IDLE, game_rst 1 for 1 cycle, score_count=0, direction=01.
